// File: rtl/branch_pkg.sv
// Shared definitions for the gshare branch predictor: branch type positions,
// opcode/rt encodings, counter states and FSM states.
package branch_pkg;

    localparam int unsigned BR_TYPES = 6;
    localparam int unsigned TYPE_W   = 3;
    localparam int unsigned STAT_W   = 32;

    localparam int unsigned BGEZ_B = 0;
    localparam int unsigned BLTZ_B = 1;
    localparam int unsigned BEQ_B  = 2;
    localparam int unsigned BNE_B  = 3;
    localparam int unsigned BLEZ_B = 4;
    localparam int unsigned BGTZ_B = 5;

    localparam logic [5:0] OP_REGIMM = 6'b000001;
    localparam logic [5:0] OP_BEQ    = 6'b000100;
    localparam logic [5:0] OP_BNE    = 6'b000101;
    localparam logic [5:0] OP_BLEZ   = 6'b000110;
    localparam logic [5:0] OP_BGTZ   = 6'b000111;

    localparam logic [4:0] RT_BGEZ = 5'b00001;
    localparam logic [4:0] RT_BLTZ = 5'b00000;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_state_t;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } bp_state_t;

    // Record of the branch currently awaiting resolution.
    typedef struct packed {
        logic [TYPE_W-1:0] pos;
        logic              taken;
    } flight_t;

endpackage

// File: rtl/sat_counter2.sv
// Next-state function of a 2-bit saturating counter.
module sat_counter2
    import branch_pkg::*;
(
    input  logic [1:0] cnt,
    input  logic       taken,
    output logic [1:0] cnt_nxt_c
);

    always_comb begin
        cnt_nxt_c = cnt;
        if (taken) begin
            if (cnt != ST) cnt_nxt_c = cnt + 2'd1;
        end else begin
            if (cnt != SNT) cnt_nxt_c = cnt - 2'd1;
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Gshare predictor: one branch in flight, 2-bit counter table indexed by
// pc XOR global history, trained by the resolution verdict.
module branch_predictor
    import branch_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 4,
    parameter logic [1:0]  CNT_INIT   = 2'b01
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pred_req,
    input  logic [5:0]  OpCode,
    input  logic [4:0]  rt,
    input  logic [31:0] pc,
    output logic [5:0]  Branch_pred_unit,
    output logic        pred_valid,
    output logic        pred_busy,
    input  logic        resolve_valid,
    input  logic [5:0]  wrong_taken,
    input  logic [5:0]  wrong_not_taken,
    input  logic        flush,
    output logic        mispredict,
    output logic [31:0] branch_count,
    output logic [31:0] mispredict_count
);

    localparam int unsigned TABLE_SIZE = 1 << INDEX_BITS;

    bp_state_t             state, state_nxt;
    logic [1:0]            cnt_table [TABLE_SIZE];
    logic [INDEX_BITS-1:0] ghr;
    logic [INDEX_BITS-1:0] idx_c;
    logic [INDEX_BITS-1:0] idx_q;
    flight_t               flight_q;
    logic                  is_branch_c;
    logic [TYPE_W-1:0]     pos_c;
    logic                  capture_c;
    logic                  train_c;
    logic                  leave_c;
    logic                  err_c;
    logic                  actual_c;
    logic [1:0]            cnt_nxt_c;
    logic                  unused_pc_c;

    assign unused_pc_c = ^{pc[31:INDEX_BITS+2], pc[1:0]};

    // Conditional branch decode into a type bit position.
    always_comb begin
        is_branch_c = 1'b0;
        pos_c       = '0;
        case (OpCode)
            OP_REGIMM: begin
                if (rt == RT_BGEZ) begin
                    is_branch_c = 1'b1;
                    pos_c       = TYPE_W'(BGEZ_B);
                end else if (rt == RT_BLTZ) begin
                    is_branch_c = 1'b1;
                    pos_c       = TYPE_W'(BLTZ_B);
                end
            end
            OP_BEQ:  begin is_branch_c = 1'b1; pos_c = TYPE_W'(BEQ_B);  end
            OP_BNE:  begin is_branch_c = 1'b1; pos_c = TYPE_W'(BNE_B);  end
            OP_BLEZ: begin is_branch_c = 1'b1; pos_c = TYPE_W'(BLEZ_B); end
            OP_BGTZ: begin is_branch_c = 1'b1; pos_c = TYPE_W'(BGTZ_B); end
            default: ;
        endcase
    end

    assign idx_c = pc[INDEX_BITS+1:2] ^ ghr;

    // Both error bits set resolves as taken regardless of the prediction.
    assign err_c    = wrong_taken[flight_q.pos] | wrong_not_taken[flight_q.pos];
    assign actual_c = (wrong_taken[flight_q.pos] & wrong_not_taken[flight_q.pos])
                    | (flight_q.taken ^ err_c);

    sat_counter2 u_sat (
        .cnt       (cnt_table[idx_q]),
        .taken     (actual_c),
        .cnt_nxt_c (cnt_nxt_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        capture_c = 1'b0;
        train_c   = 1'b0;
        leave_c   = 1'b0;
        case (state)
            IDLE: begin
                if (pred_req && is_branch_c) begin
                    capture_c = 1'b1;
                    state_nxt = PENDING;
                end
            end
            PENDING: begin
                if (flush) begin
                    leave_c   = 1'b1;
                    state_nxt = IDLE;
                end else if (resolve_valid) begin
                    train_c   = 1'b1;
                    leave_c   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < TABLE_SIZE; i++) cnt_table[i] <= CNT_INIT;
            ghr              <= '0;
            idx_q            <= '0;
            flight_q         <= '0;
            Branch_pred_unit <= '0;
            pred_valid       <= 1'b0;
            pred_busy        <= 1'b0;
            mispredict       <= 1'b0;
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            mispredict <= 1'b0;
            if (capture_c) begin
                flight_q.pos     <= pos_c;
                flight_q.taken   <= cnt_table[idx_c][1];
                idx_q            <= idx_c;
                Branch_pred_unit <= 6'(cnt_table[idx_c][1]) << pos_c;
                pred_valid       <= 1'b1;
                pred_busy        <= 1'b1;
            end
            if (train_c) begin
                cnt_table[idx_q] <= cnt_nxt_c;
                ghr              <= {ghr[INDEX_BITS-2:0], actual_c};
                mispredict       <= err_c;
                if (branch_count != '1) branch_count <= branch_count + 32'd1;
                if (err_c && (mispredict_count != '1))
                    mispredict_count <= mispredict_count + 32'd1;
            end
            if (leave_c) begin
                Branch_pred_unit <= '0;
                pred_valid       <= 1'b0;
                pred_busy        <= 1'b0;
            end
        end
    end

endmodule
